bilateral_filter_pipe: RTL and testbench

Second-generation edge-preserving 3x3 bilateral filter for the Sobel video path. It sits between the line-buffer window generator and the Sobel gradient stage. Compared with the first-generation filter it adds:
- runtime two-tier range thresholds,
- round-to-nearest normalisation through a fully pipelined restoring divider,
- a bypass mode,
- valid/ready backpressure.

Only the centre pixel is filtered; the other eight window pixels pass through unchanged, time-aligned with the centre.

---
 rtl/bilateral_filter_pipe.sv | 190 +++++++++++++++++++
 tb/tb_bilateral_filter_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bilateral_filter_pipe.sv
// Edge-preserving 3x3 bilateral filter on the window centre, with two-tier range weights,
// round-half-up normalisation through a pipelined restoring divider, bypass and valid/ready.
module bilateral_filter_pipe #(
    parameter int PIXEL_WIDTH = 8,
    parameter int THR_WIDTH   = PIXEL_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PIXEL_WIDTH*9-1:0] window_in,
    input  logic [THR_WIDTH-1:0]     thr_near,
    input  logic [THR_WIDTH-1:0]     thr_far,
    input  logic                     bypass,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PIXEL_WIDTH*9-1:0] window_out
);
    localparam int PW = PIXEL_WIDTH;
    localparam int WW = PW * 9;
    localparam int NW = PW + 6;
    localparam int CW = (PW > THR_WIDTH) ? PW : THR_WIDTH;

    logic en;
    logic take;

    logic [PW-1:0] centre_in;
    logic [PW-1:0] diff   [9];
    logic [3:0]    nbr_w  [9];

    logic          s1_valid_q, s1_valid_d;
    logic [3:0]    s1_w_q [9];
    logic [3:0]    s1_w_d [9];
    logic [WW-1:0] s1_win_q, s1_win_d;
    logic          s1_byp_q, s1_byp_d;

    logic [5:0]    wsum_c;
    logic [NW-1:0] sum_c;

    // Index 0 is the weighted-sum stage; indices 1..PW each resolve one quotient bit.
    logic          dv_valid_q [PW+1];
    logic          dv_valid_d [PW+1];
    logic [NW-1:0] dv_rem_q   [PW+1];
    logic [NW-1:0] dv_rem_d   [PW+1];
    logic [PW-1:0] dv_quo_q   [PW+1];
    logic [PW-1:0] dv_quo_d   [PW+1];
    logic [5:0]    dv_wsum_q  [PW+1];
    logic [5:0]    dv_wsum_d  [PW+1];
    logic [WW-1:0] dv_win_q   [PW+1];
    logic [WW-1:0] dv_win_d   [PW+1];
    logic          dv_byp_q   [PW+1];
    logic          dv_byp_d   [PW+1];
    logic [NW-1:0] div_sub    [PW+1];

    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign take      = in_valid && en;
    assign centre_in = window_in[4*PW +: PW];

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            diff[k]  = (window_in[k*PW +: PW] >= centre_in) ? window_in[k*PW +: PW] - centre_in
                                                            : centre_in - window_in[k*PW +: PW];
            nbr_w[k] = 4'd0;
            if (k == 4) begin
                nbr_w[k] = 4'd8;
            end else if (CW'(diff[k]) < CW'(thr_near)) begin
                nbr_w[k] = (k % 2 == 1) ? 4'd4 : 4'd2;
            end else if (CW'(diff[k]) < CW'(thr_far)) begin
                nbr_w[k] = (k % 2 == 1) ? 4'd2 : 4'd1;
            end
        end
    end

    always_comb begin
        s1_valid_d = en ? in_valid : s1_valid_q;
        s1_win_d   = s1_win_q;
        s1_byp_d   = s1_byp_q;
        for (int k = 0; k < 9; k++) begin
            s1_w_d[k] = s1_w_q[k];
        end
        if (take) begin
            s1_win_d = window_in;
            s1_byp_d = bypass;
            for (int k = 0; k < 9; k++) begin
                s1_w_d[k] = nbr_w[k];
            end
        end
    end

    always_comb begin
        wsum_c = '0;
        sum_c  = '0;
        for (int k = 0; k < 9; k++) begin
            wsum_c = wsum_c + 6'(s1_w_q[k]);
            sum_c  = sum_c + NW'(s1_win_q[k*PW +: PW]) * NW'(s1_w_q[k]);
        end
    end

    // Divisor aligned to the quotient bit resolved by each divider stage.
    always_comb begin
        for (int j = 0; j <= PW; j++) begin
            div_sub[j] = '0;
        end
        for (int j = 1; j <= PW; j++) begin
            div_sub[j] = NW'(dv_wsum_q[j-1]) << (PW - j);
        end
    end

    always_comb begin
        for (int j = 0; j <= PW; j++) begin
            dv_valid_d[j] = dv_valid_q[j];
            dv_rem_d[j]   = dv_rem_q[j];
            dv_quo_d[j]   = dv_quo_q[j];
            dv_wsum_d[j]  = dv_wsum_q[j];
            dv_win_d[j]   = dv_win_q[j];
            dv_byp_d[j]   = dv_byp_q[j];
        end
        if (en) begin
            dv_valid_d[0] = s1_valid_q;
            if (s1_valid_q) begin
                dv_rem_d[0]  = sum_c + NW'(wsum_c >> 1);
                dv_quo_d[0]  = '0;
                dv_wsum_d[0] = wsum_c;
                dv_win_d[0]  = s1_win_q;
                dv_byp_d[0]  = s1_byp_q;
            end
            for (int j = 1; j <= PW; j++) begin
                dv_valid_d[j] = dv_valid_q[j-1];
                if (dv_valid_q[j-1]) begin
                    dv_wsum_d[j] = dv_wsum_q[j-1];
                    dv_win_d[j]  = dv_win_q[j-1];
                    dv_byp_d[j]  = dv_byp_q[j-1];
                    if (dv_rem_q[j-1] >= div_sub[j]) begin
                        dv_rem_d[j] = dv_rem_q[j-1] - div_sub[j];
                        dv_quo_d[j] = {dv_quo_q[j-1][PW-2:0], 1'b1};
                    end else begin
                        dv_rem_d[j] = dv_rem_q[j-1];
                        dv_quo_d[j] = {dv_quo_q[j-1][PW-2:0], 1'b0};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_win_q   <= '0;
            s1_byp_q   <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                s1_w_q[k] <= '0;
            end
            for (int j = 0; j <= PW; j++) begin
                dv_valid_q[j] <= 1'b0;
                dv_rem_q[j]   <= '0;
                dv_quo_q[j]   <= '0;
                dv_wsum_q[j]  <= '0;
                dv_win_q[j]   <= '0;
                dv_byp_q[j]   <= 1'b0;
            end
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_win_q   <= s1_win_d;
            s1_byp_q   <= s1_byp_d;
            for (int k = 0; k < 9; k++) begin
                s1_w_q[k] <= s1_w_d[k];
            end
            for (int j = 0; j <= PW; j++) begin
                dv_valid_q[j] <= dv_valid_d[j];
                dv_rem_q[j]   <= dv_rem_d[j];
                dv_quo_q[j]   <= dv_quo_d[j];
                dv_wsum_q[j]  <= dv_wsum_d[j];
                dv_win_q[j]   <= dv_win_d[j];
                dv_byp_q[j]   <= dv_byp_d[j];
            end
        end
    end

    // The last stage still carries the original centre, so bypass just keeps it.
    assign out_valid = dv_valid_q[PW];

    always_comb begin
        window_out = dv_win_q[PW];
        if (!dv_byp_q[PW]) begin
            window_out[4*PW +: PW] = dv_quo_q[PW];
        end
    end

endmodule

// File: tb/tb_bilateral_filter_pipe.sv
// Directed bench for bilateral_filter_pipe: a spec-level window model feeds a scoreboard,
// and literal expectations pin both the model and the DUT on hand-worked windows.
module tb_bilateral_filter_pipe;
    localparam int PW = 8;
    localparam int WW = PW * 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WW-1:0] window_in = '0;
    logic [PW-1:0] thr_near = '0;
    logic [PW-1:0] thr_far = '0;
    logic          bypass = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [WW-1:0] window_out;

    int            n_cmp = 0;
    int            n_fail = 0;
    int            n_out = 0;
    int            cyc = 0;
    bit            lat_check_en = 1'b1;
    bit            prev_stall = 1'b0;
    logic [WW-1:0] prev_win = '0;
    logic [WW-1:0] last_out = '0;
    logic [WW-1:0] exp_q [$];
    int            acc_q [$];

    bilateral_filter_pipe #(.PIXEL_WIDTH(PW), .THR_WIDTH(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .window_in  (window_in),
        .thr_near   (thr_near),
        .thr_far    (thr_far),
        .bypass     (bypass),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .window_out (window_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected window straight from the weighting rules: round-half-up of sum/wsum.
    function automatic logic [WW-1:0] modelWindow(input logic [WW-1:0] w, input int tn,
                                                  input int tf, input bit byp);
        int c, p, d, wt, full, wsum, sum;
        logic [WW-1:0] r;
        r    = w;
        c    = int'(w[4*PW +: PW]);
        wsum = 8;
        sum  = 8 * c;
        for (int k = 0; k < 9; k++) begin
            if (k != 4) begin
                p    = int'(w[k*PW +: PW]);
                d    = (p > c) ? p - c : c - p;
                full = (k % 2 == 1) ? 4 : 2;
                if (d < tn) wt = full;
                else if (d < tf) wt = full / 2;
                else wt = 0;
                wsum += wt;
                sum  += p * wt;
            end
        end
        if (!byp) r[4*PW +: PW] = PW'((2 * sum + wsum) / (2 * wsum));
        return r;
    endfunction

    function automatic logic [WW-1:0] mkWin(input int c, input int n);
        logic [WW-1:0] w;
        for (int k = 0; k < 9; k++) w[k*PW +: PW] = PW'(n);
        w[4*PW +: PW] = PW'(c);
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [WW-1:0] actual,
                               input logic [WW-1:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Called at posedge+1; holds the window until the DUT takes it.
    task automatic applyStimulus(input logic [WW-1:0] win, input int tn, input int tf,
                                 input bit byp);
        bit done;
        done      = 1'b0;
        window_in = win;
        thr_near  = PW'(tn);
        thr_far   = PW'(tf);
        bypass    = byp;
        in_valid  = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) checkOutput("accept_timeout", WW'(0), WW'(1));
    endtask

    task automatic waitOutputs(input int target, input string name);
        for (int t = 0; t < 300 && n_out < target; t++) begin
            @(posedge clk);
            #1;
        end
        checkOutput(name, WW'(n_out), WW'(target));
    endtask

    task automatic runDirected(input string name, input logic [WW-1:0] win, input int tn,
                               input int tf, input bit byp, input int exp_c);
        int target;
        logic [WW-1:0] m;
        m = modelWindow(win, tn, tf, byp);
        checkOutput({name, "_model"}, WW'(m[4*PW +: PW]), WW'(exp_c));
        target = n_out + 1;
        applyStimulus(win, tn, tf, byp);
        waitOutputs(target, {name, "_count"});
        checkOutput({name, "_slot4"}, WW'(last_out[4*PW +: PW]), WW'(exp_c));
    endtask

    // Scoreboard: record accepted windows, check every delivered window and the handshake rules.
    always @(negedge clk) begin
        logic [WW-1:0] e;
        int a;
        if (rst_n) begin
            checkOutput("in_ready_rule", WW'(in_ready), WW'(!out_valid || out_ready));
            if (prev_stall) begin
                checkOutput("stall_hold_valid", WW'(out_valid), WW'(1));
                checkOutput("stall_hold_data", window_out, prev_win);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(modelWindow(window_in, int'(thr_near), int'(thr_far), bypass));
                acc_q.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_output", window_out, '0);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    checkOutput("window", window_out, e);
                    if (lat_check_en) checkOutput("latency", WW'(cyc - a), WW'(PW + 2));
                end
                last_out = window_out;
                n_out++;
            end
            prev_stall = out_valid && !out_ready;
            prev_win   = window_out;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [WW-1:0] w;
        int base, tn, tf;

        #1;
        checkOutput("reset_out_valid", WW'(out_valid), WW'(0));
        checkOutput("reset_window_out", window_out, '0);
        checkOutput("reset_in_ready", WW'(in_ready), WW'(1));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        runDirected("flat100", mkWin(100, 100), 20, 40, 1'b0, 100);
        checkOutput("flat100_window", last_out, mkWin(100, 100));
        runDirected("round_up", mkWin(10, 12), 20, 40, 1'b0, 12);
        runDirected("half_tier", mkWin(100, 130), 20, 40, 1'b0, 118);
        runDirected("empty_half", mkWin(100, 130), 20, 20, 1'b0, 100);
        w = mkWin(100, 100);
        for (int k = 0; k < 3; k++) w[k*PW +: PW] = 8'd200;
        runDirected("top_row", w, 20, 40, 1'b0, 100);
        checkOutput("top_row_slots012", WW'(last_out[3*PW-1:0]), WW'(24'hC8C8C8));
        w = mkWin(77, 80);
        w[0 +: PW] = 8'd77;
        w[5*PW +: PW] = 8'd3;
        runDirected("thr_zero", w, 0, 0, 1'b0, 77);
        runDirected("bypass_lit", mkWin(10, 12), 20, 40, 1'b1, 10);

        // Alternating bypass on varied windows, back to back at full rate.
        base = n_out;
        for (int i = 0; i < 12; i++) begin
            for (int s = 0; s < 9; s++) w[s*PW +: PW] = PW'(i * 13 + s * 29);
            applyStimulus(w, 60, 120, (i % 2) == 1);
        end
        waitOutputs(base + 12, "bypass_stream_count");

        // Ramp stream with random gaps and a 5-cycle downstream stall.
        lat_check_en = 1'b0;
        base = n_out;
        fork
            begin
                for (int i = 0; i < 50; i++) begin
                    for (int s = 0; s < 9; s++) w[s*PW +: PW] = PW'(i * 5 + s * 9);
                    tn = 10 + (i % 4) * 8;
                    tf = tn + ((i % 3) - 1) * 15;
                    applyStimulus(w, tn, tf, 1'b0);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
            begin
                repeat (25) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        waitOutputs(base + 50, "stream_count");
        checkOutput("stream_queue_empty", WW'(exp_q.size()), WW'(0));
        lat_check_en = 1'b1;

        // Reset with windows in flight; nothing from before it may come out afterwards.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(mkWin(40 + i, 50 + i), 20, 40, 1'b0);
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", WW'(out_valid), WW'(0));
        checkOutput("midreset_window_out", window_out, '0);
        exp_q.delete();
        acc_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checkOutput("postreset_in_ready", WW'(in_ready), WW'(1));
        base = n_out;
        repeat (15) @(posedge clk);
        #1;
        checkOutput("postreset_no_stale", WW'(n_out), WW'(base));
        runDirected("after_reset", mkWin(100, 130), 20, 40, 1'b0, 118);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
